sdram_port_arbiter: RTL

// - Two-client front end that shares one sdram_control instance between requesters.
// - Selects a client with round-robin arbitration and issues one burst to the controller.
// - Counts the controller's data strobes to detect burst completion, and routes write data and read data.
// - Sits between the user datapaths (for example a capture writer and a display reader) and sdram_control.

---
 rtl/sdram_port_arbiter_if.sv | 44 ++++
 rtl/sdram_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if
// One client port of the SDRAM port arbiter. Instantiate one per client.
//   master : the user datapath (drives request, address and write data)
//   slave  : the arbiter (drives ack, write-data request, read data, status)
// Signals:
//   req        client request, held until ack
//   we         1 = write burst, 0 = read burst
//   bank/row/col  burst start address
//   ack        1-cycle pulse: request accepted, address captured
//   wdata      write word; advanced by the client after each wdata_req
//   wdata_req  client presents the next write word on the following cycle
//   rdata      read word, valid with rdata_vld
//   done       1-cycle pulse: burst complete
//   err        1-cycle pulse: burst aborted on beat timeout
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9
);
  logic              req;
  logic              we;
  logic [1:0]        bank;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              ack;
  logic [DATA_W-1:0] wdata;
  logic              wdata_req;
  logic [DATA_W-1:0] rdata;
  logic              rdata_vld;
  logic              done;
  logic              err;

  modport master (
    output req, we, bank, row, col, wdata,
    input  ack, wdata_req, rdata, rdata_vld, done, err
  );

  modport slave (
    input  req, we, bank, row, col, wdata,
    output ack, wdata_req, rdata, rdata_vld, done, err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
// Two-client front end sharing one sdram_control instance. A round-robin
// arbiter picks a client, one burst command is issued, the controller's data
// strobes are counted to find the end of the burst, and write/read data are
// routed between the granted client and the controller. A burst whose beats
// stop arriving for TIMEOUT cycles is aborted with an err pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   c0, c1              client ports (sdram_port_arbiter_if.slave)
//   wr_en_o / rd_en_o   1-cycle command pulse to the controller
//   bank/row/col_addr_o registered command address, held until next command
//   wr_data_o           write data of the granted client, 0 when idle
//   rd_data_i           read data from the controller
//   rddata_vld_i        read beat strobe from the controller
//   wrdata_vld_i        write beat strobe from the controller
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 9,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_port_arbiter_if.slave  c0,
  sdram_port_arbiter_if.slave  c1,
  output logic                 wr_en_o,
  output logic                 rd_en_o,
  output logic [1:0]           bank_addr_o,
  output logic [ROW_W-1:0]     row_addr_o,
  output logic [COL_W-1:0]     col_addr_o,
  output logic [DATA_W-1:0]    wr_data_o,
  input  logic [DATA_W-1:0]    rd_data_i,
  input  logic                 rddata_vld_i,
  input  logic                 wrdata_vld_i
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int TMO_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;          // 0 = client 0, 1 = client 1
  logic               we_q, we_d;
  logic               rr_last_q, rr_last_d;  // client served most recently
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [1:0]         bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [DATA_W-1:0]  rdata0_q, rdata1_q;
  logic               rvld0_q, rvld1_q;

  logic in_data;
  logic abort;
  logic strobe;
  logic wr_strobe;
  logic rd_strobe;

  // Abort fires in the cycle the idle counter would reach TIMEOUT, so err
  // lands exactly TIMEOUT cycles after the last counted beat. Abort wins over
  // a beat arriving in that same cycle.
  assign in_data   = (state_q == S_DATA);
  assign abort     = in_data && (tmo_q == TMO_W'(TIMEOUT - 1));
  // Only the strobe matching the burst direction counts.
  assign strobe    = we_q ? wrdata_vld_i : rddata_vld_i;
  assign wr_strobe = in_data && !abort && we_q  && wrdata_vld_i;
  assign rd_strobe = in_data && !abort && !we_q && rddata_vld_i;

  // NOTE: every signal written here gets its default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    rr_last_d = rr_last_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;

    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        tmo_d  = '0;
        if (c0.req || c1.req) begin
          // Contention goes to the client that was not served last.
          gnt_d   = (c0.req && c1.req) ? ~rr_last_q : c1.req;
          we_d    = gnt_d ? c1.we   : c0.we;
          bank_d  = gnt_d ? c1.bank : c0.bank;
          row_d   = gnt_d ? c1.row  : c0.row;
          col_d   = gnt_d ? c1.col  : c0.col;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        beat_d  = '0;
        tmo_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (abort) begin
          rr_last_d = gnt_q;
          state_d   = S_IDLE;
        end else if (strobe) begin
          tmo_d  = '0;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        rr_last_d = gnt_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      rr_last_q <= 1'b1;
      beat_q    <= '0;
      tmo_q     <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  // Read data path: one register per client so the idle client's rdata
  // stays at its last value (0 after reset) and never shows the other
  // client's traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      rvld0_q  <= 1'b0;
      rvld1_q  <= 1'b0;
    end else begin
      rvld0_q <= rd_strobe && !gnt_q;
      rvld1_q <= rd_strobe && gnt_q;
      if (rd_strobe && !gnt_q) rdata0_q <= rd_data_i;
      if (rd_strobe && gnt_q)  rdata1_q <= rd_data_i;
    end
  end

  // Controller side
  assign wr_en_o     = (state_q == S_ISSUE) && we_q;
  assign rd_en_o     = (state_q == S_ISSUE) && !we_q;
  assign bank_addr_o = bank_q;
  assign row_addr_o  = row_q;
  assign col_addr_o  = col_q;
  assign wr_data_o   = (state_q == S_IDLE) ? '0 : (gnt_q ? c1.wdata : c0.wdata);

  // Client side
  assign c0.ack       = (state_q == S_ISSUE) && !gnt_q;
  assign c1.ack       = (state_q == S_ISSUE) && gnt_q;
  assign c0.done      = (state_q == S_DONE) && !gnt_q;
  assign c1.done      = (state_q == S_DONE) && gnt_q;
  assign c0.err       = abort && !gnt_q;
  assign c1.err       = abort && gnt_q;
  assign c0.wdata_req = wr_strobe && !gnt_q;
  assign c1.wdata_req = wr_strobe && gnt_q;
  assign c0.rdata     = rdata0_q;
  assign c1.rdata     = rdata1_q;
  assign c0.rdata_vld = rvld0_q;
  assign c1.rdata_vld = rvld1_q;

endmodule
